// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-requester data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_t;

  typedef logic req_id_t;

  localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on a tie the requester that did not win last time is chosen.
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] eligible,
  input  req_id_t    last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = eligible;
    if (eligible == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter and sequencer sharing a single-port data memory between the core (req 0)
// and the loader/debug port (req 1); one access per grant, response one cycle later.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_we,
  input  logic [1:0]            req_lock,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*WIDTH-1:0]    req_wdata,
  input  logic [7:0]            req_wstrb,
  output logic [1:0]            rsp_valid,
  output logic                  rsp_err,
  output logic [WIDTH-1:0]      rsp_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-3:0]     mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic [WIDTH-1:0]      mem_rdata
);

  arb_state_t state_q, state_d;
  req_id_t    last_grant_q, last_grant_d;
  req_id_t    owner_q, owner_d;
  logic       locked_q, locked_d;
  logic       err_q, err_d;
  logic       is_load_q, is_load_d;

  logic [1:0]        eligible;
  logic [1:0]        grant;
  req_id_t           winner;
  logic              handshake;
  logic              aligned;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [WIDTH-1:0]  win_wdata;
  logic [3:0]        win_wstrb;
  logic              rsp_active;
  logic              unused_lock;

  assign unused_lock = req_lock[1];

  // Nothing is granted while reset is high; the lock masks requester 1 out before picking.
  assign eligible = (state_q == IDLE && !reset)
                    ? (req_valid & (locked_q ? 2'b01 : 2'b11))
                    : 2'b00;

  rr_pick2 u_pick (
    .eligible   (eligible),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  always_comb begin
    winner    = grant[1];
    handshake = |grant;
    win_we    = winner ? req_we[1] : req_we[0];
    win_addr  = winner ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
    win_wdata = winner ? req_wdata[2*WIDTH-1:WIDTH] : req_wdata[WIDTH-1:0];
    win_wstrb = winner ? req_wstrb[7:4] : req_wstrb[3:0];
    aligned   = (win_addr[1:0] & ALIGN_MASK) == 2'b00;
  end

  always_comb begin
    req_ready = grant;
    mem_en    = handshake && aligned;
    mem_we    = mem_en && win_we;
    mem_addr  = mem_en ? win_addr[ADDR_W-1:2] : '0;
    mem_wdata = mem_en ? win_wdata : '0;
    mem_wstrb = mem_en ? win_wstrb : 4'b0000;
  end

  // A response in flight is suppressed if reset lands on the WAIT cycle.
  always_comb begin
    rsp_active = (state_q == WAIT) && !reset;
    rsp_valid  = rsp_active ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    rsp_err    = rsp_active && err_q;
    rsp_rdata  = (rsp_active && is_load_q && !err_q) ? mem_rdata : '0;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    locked_d     = locked_q;
    err_d        = err_q;
    is_load_d    = is_load_q;
    unique case (state_q)
      IDLE: begin
        if (handshake) begin
          state_d      = WAIT;
          owner_d      = winner;
          last_grant_d = winner;
          err_d        = !aligned;
          is_load_d    = !win_we;
          if (!winner) begin
            locked_d = req_lock[0];
          end
        end
      end
      WAIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
      is_load_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      locked_q     <= locked_d;
      err_q        <= err_d;
      is_load_q    <= is_load_d;
    end
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and sequencer for the shared single-port data memory. It shares the memory between the core load/store port (requester 0) and the loader/debug port (requester 1). It accepts one valid/ready request per grant, drives the memory for one cycle, and returns a response one cycle later. It provides round-robin fairness, a requester-0 lock for read-modify-write sequences, and misalignment rejection. It sits between the processor datapath and the data memory macro (1-cycle synchronous read latency).

## Interface
- WIDTH, 32: data word width.
- ADDR_W, 10: byte-address width; word index is addr[ADDR_W-1:2].
- clock  in  1  single clock; all state on rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  2  request valid, bit n = requester n.
- req_ready  out  2  one-hot grant; handshake when valid&ready.
- req_we  in  2  1 = store.
- req_lock  in  2  only bit 0 honoured; bit 1 ignored.
- req_addr  in  2×ADDR_W  byte address per requester.
- req_wdata  in  2×WIDTH  store data.
- req_wstrb  in  2×4  byte enables, bit k = byte k.
- rsp_valid  out  2  one-cycle response pulse to owner.
- rsp_err  out  1  misaligned access; qualified by rsp_valid.
- rsp_rdata  out  WIDTH  load data; 0 for stores and errors.
- mem_en  out  1  memory access this cycle.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_W-2  word index.
- mem_wdata  out  WIDTH  write data.
- mem_wstrb  out  4  byte enables.
- mem_rdata  in  WIDTH  valid the cycle after mem_en&!mem_we.

## Operation
- FSM states: IDLE, WAIT.
- IDLE with no valid: req_ready=0, mem_en=0.
- IDLE with any valid: pick a winner, assert its req_ready bit and go to WAIT.
  - Aligned request (addr[1:0]==0): drive mem_* from the winner the same cycle.
  - Misaligned request: mem_en=0.
- WAIT: assert rsp_valid[owner] for exactly one cycle, then return to IDLE; req_ready=0.
  - rsp_rdata = mem_rdata for an aligned load, else 0.
  - rsp_err = 1 only if the accepted request was misaligned.
- Round-robin: register last_grant.
  - Both valid: winner = !last_grant.
  - One valid: that one wins.
  - last_grant updates on every handshake.
- Lock: a requester-0 handshake with req_lock[0]=1 sets `locked`.
  - While locked, only requester 0 is eligible; requester 1 starves.
  - A requester-0 handshake with req_lock[0]=0 clears `locked`.
- Stores with wstrb=0 still issue mem_en=1 and still get a response.
- Requesters must hold request fields stable while valid && !ready. The arbiter does not check this.

## Timing
- Reset values: state=IDLE, last_grant=1 (requester 0 wins first tie), locked=0.
  - All outputs 0: req_ready, rsp_valid, rsp_err, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb.
- req_ready and mem_* are combinational from state, locked, last_grant and req_*. There is no path from rsp to req.
- Latency: handshake at cycle t, rsp_valid at t+1, next grant no earlier than t+2. Peak throughput is 1 access per 2 cycles.
- Simultaneous valid in IDLE: exactly one bit of req_ready is high, never both.
- Reset during WAIT: the response is dropped (rsp_valid=0 next cycle) and state goes to IDLE. A store already issued to memory stands.
- Reset asserted in the same cycle as valid: no handshake, no mem_en.
- A new req_valid arriving during WAIT is held off until IDLE.

## Structure
- Package dmem_arb_pkg:
  - state enum `arb_state_t` {IDLE, WAIT}.
  - `req_id_t` (1 bit).
  - Localparam `ALIGN_MASK` = 2'b11.
- Sub-module rr_pick2: combinational two-way round-robin picker.
  - Inputs: eligible[1:0], last_grant. Output: one-hot grant.
  - Lock masking is applied by the parent before rr_pick2.
- Parent holds the FSM, last_grant, locked, the owner/err/is-load registers and the output muxing.

## Test plan
- Reset, then req_valid=2'b01 load addr 0x010 with mem holding 0xDEADBEEF at word 4 → t: req_ready=01, mem_en=1, mem_addr=4. t+1: rsp_valid=01, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Both valid continuously, loads → grants alternate 0,1,0,1 on cycles 0,2,4,6. No cycle has req_ready=11.
- Req0 store addr 0x020, wdata 0x11223344, wstrb 4'b0011 → mem_we=1, mem_addr=8, mem_wstrb=0011. Response rdata=0. A subsequent load of 0x020 returns the merged word.
- Req1 load addr 0x006 → mem_en=0 throughout, rsp_valid=10 with rsp_err=1 and rdata=0. last_grant=1.
- Req0 handshake with lock=1 while req1 is valid; req0 issues two more requests, the second with lock=0 → req1 is not granted until the cycle after req0's lock=0 response.
- Assert reset in WAIT after a load handshake → rsp_valid stays 0, state=IDLE, last_grant=1. The next tie grants requester 0.
